// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN to build two's-complement support; otherwise unsigned only.
module div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
    input  logic             sign,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic             a_neg, b_neg;
    logic [WIDTH:0]   rem_sh, rem_nxt;
    logic [WIDTH+1:0] diff;
    logic             step_ok;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] q_fin, r_fin;

`ifdef DIV_SIGNED_EN
    logic q_sign_q, q_sign_d;
    logic r_sign_q, r_sign_d;

    always_comb begin
        a_neg = sign & a[WIDTH-1];
        b_neg = sign & b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_sign_q <= 1'b0;
            r_sign_q <= 1'b0;
        end else begin
            q_sign_q <= q_sign_d;
            r_sign_q <= r_sign_d;
        end
    end
`else
    logic unused_sign;
    assign unused_sign = sign;

    always_comb begin
        a_neg = 1'b0;
        b_neg = 1'b0;
        a_mag = a;
        b_mag = b;
    end
`endif

    // Restoring step: the dividend register shifts out into the remainder and
    // collects quotient bits from the bottom.
    always_comb begin
        rem_sh  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        diff    = {1'b0, rem_sh} - {2'b00, dvs_q};
        step_ok = ~diff[WIDTH+1];
        rem_nxt = step_ok ? diff[WIDTH:0] : rem_sh;
        quo_nxt = {quo_q[WIDTH-2:0], step_ok};
    end

    // With a zero divisor every trial succeeds, so the remainder ends as |a|
    // and sign correction restores the original dividend.
    always_comb begin
`ifdef DIV_SIGNED_EN
        q_fin = q_sign_q ? -quo_nxt : quo_nxt;
        r_fin = r_sign_q ? -rem_nxt[WIDTH-1:0] : rem_nxt[WIDTH-1:0];
`else
        q_fin = quo_nxt;
        r_fin = rem_nxt[WIDTH-1:0];
`endif
        if (zero_q) begin
            q_fin = '1;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        zero_d     = zero_q;
        q_d        = q_q;
        r_d        = r_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
`ifdef DIV_SIGNED_EN
        q_sign_d   = q_sign_q;
        r_sign_d   = r_sign_q;
`endif
        if (state_q == IDLE) begin
            if (start) begin
                quo_d   = a_mag;
                rem_d   = '0;
                dvs_d   = b_mag;
                zero_d  = (b == '0);
                cnt_d   = '0;
                state_d = RUN;
`ifdef DIV_SIGNED_EN
                q_sign_d = a_neg ^ b_neg;
                r_sign_d = a_neg;
`endif
            end
        end else begin
            quo_d = quo_nxt;
            rem_d = rem_nxt;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                q_d        = q_fin;
                r_d        = r_fin;
                div_zero_d = zero_q;
                done_d     = 1'b1;
                cnt_d      = '0;
                state_d    = IDLE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            zero_q     <= 1'b0;
            q_q        <= '0;
            r_q        <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            zero_q     <= zero_d;
            q_q        <= q_d;
            r_q        <= r_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign q        = q_q;
    assign r        = r_q;
    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: the driver queues expected results at issue,
// the monitor checks them whenever done pulses.
module tb_div_seq;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         start = 1'b0;
    logic         sign = 1'b0;
    logic [W-1:0] q, r;
    logic         busy, done, div_zero;

    div_seq #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .a(a), .b(b), .start(start), .sign(sign),
        .q(q), .r(r), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Monitor
    always @(negedge clock) begin
        if (!reset && done) begin
            chk("done_not_with_busy", {31'b0, busy}, 32'd0);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", q, e.q);
                chk("remainder", r, e.r);
                chk("div_zero", {31'b0, div_zero}, {31'b0, e.dz});
                chk("latency", W'(cyc), W'(e.cyc));
            end
        end
    end

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic ts, input logic [W-1:0] eq,
                         input logic [W-1:0] er, input logic edz);
        @(negedge clock);
        a = ta;
        b = tb;
        sign = ts;
        start = 1'b1;
        @(posedge clock);
        #1;
        sb.push_back('{q: eq, r: er, dz: edz, cyc: cyc + W});
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < W + 8; k++) begin
            @(negedge clock);
            if (done) break;
        end
        if (k == W + 8) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", W + 8);
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic ts, input logic [W-1:0] eq,
                          input logic [W-1:0] er, input logic edz);
        issue(ta, tb, ts, eq, er, edz);
        wait_done();
    endtask

    task automatic check_reset_state(string tag);
        chk({tag, "_q"}, q, 32'd0);
        chk({tag, "_r"}, r, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_div_zero"}, {31'b0, div_zero}, 32'd0);
    endtask

    initial begin
        int c0;
        repeat (2) @(posedge clock);
        #1;
        check_reset_state("reset");
        @(negedge clock);
        reset = 1'b0;

        run_op(32'd1, 32'd2, 1'b0, 32'd0, 32'd1, 1'b0);
        run_op(32'hFFFF_FFFF, 32'd2, 1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0);
`ifdef DIV_SIGNED_EN
        run_op(32'hFFFF_FFFF, 32'd2, 1'b1, 32'd0, 32'hFFFF_FFFF, 1'b0);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
`else
        run_op(32'hFFFF_FFFF, 32'd2, 1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0);
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 32'd0, 32'd7, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0);
`endif
        run_op(32'd55, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd55, 1'b1);
        run_op(32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
        run_op(32'd55, 32'd2, 1'b0, 32'd27, 32'd1, 1'b0);

        // start held high; operands change mid-op and become the second op
        @(negedge clock);
        a = 32'd100;
        b = 32'd7;
        sign = 1'b0;
        start = 1'b1;
        @(posedge clock);
        #1;
        c0 = cyc;
        sb.push_back('{q: 32'd14, r: 32'd2, dz: 1'b0, cyc: c0 + W});
        sb.push_back('{q: 32'd22, r: 32'd2, dz: 1'b0, cyc: c0 + 2 * W + 1});
        a = 32'd200;
        b = 32'd9;
        wait_done();
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("b2b_accept_busy", {31'b0, busy}, 32'd1);
        wait_done();

        // reset during iteration 10 aborts the op
        issue(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0);
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        void'(sb.pop_back());
        @(posedge clock);
        #1;
        check_reset_state("abort");
        @(negedge clock);
        reset = 1'b0;
        repeat (W + 4) @(negedge clock);

        run_op(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0);
        repeat (3) @(negedge clock);
        chk("scoreboard_empty", W'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_seq.md
# div_seq

Parametrised sequential radix-2 integer divider, the successor to the 32-bit unsigned `divu` unit in the CPU_55 execute stage. It accepts a dividend and divisor on a start pulse and iterates one quotient bit per clock. It returns quotient, remainder, a one-cycle done pulse and a divide-by-zero flag. It adds signed mode, a width parameter, defined divide-by-zero results and a completion handshake to the original unit.

## Interface

Parameters:
- `WIDTH`, 32, operand/result width in bits (≥ 4)
- `CNT_W`, $clog2(WIDTH)+1, iteration counter width (derived, do not override)

Ports:
- `clock`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `a`  in  WIDTH  dividend, sampled on accepted start
- `b`  in  WIDTH  divisor, sampled on accepted start
- `start`  in  1  request; accepted only when `busy`=0
- `sign`  in  1  1 = two's-complement operands, 0 = unsigned; sampled with `a`/`b`
- `q`  out  WIDTH  quotient, registered
- `r`  out  WIDTH  remainder, registered
- `busy`  out  1  high while iterating
- `done`  out  1  one-cycle pulse when `q`/`r` update
- `div_zero`  out  1  registered with `q`/`r`; 1 if captured `b` was 0

## Operation

- States: IDLE, RUN. Reset → IDLE.
- IDLE, `start`=1:
  - capture |a|, |b| (magnitudes in signed mode; raw values in unsigned mode);
  - capture quotient sign = a[MSB]^b[MSB], remainder sign = a[MSB] (both forced 0 when unsigned);
  - capture zero flag = (b==0);
  - counter ← 0; → RUN.
- RUN, each cycle: restoring step on WIDTH+1-bit partial remainder:
  - shift in next dividend bit;
  - trial subtract divisor magnitude;
  - if non-negative, keep the difference and set the quotient bit, else restore;
  - counter++.
- RUN, on the cycle counter reaches WIDTH-1:
  - apply sign correction (negate quotient and/or remainder magnitude);
  - write `q`, `r`, `div_zero`; pulse `done`; → IDLE.
- Arithmetic rules:
  - quotient truncates toward zero; remainder takes the sign of the dividend; |r| < |b|;
  - signed overflow (-2^(WIDTH-1) / -1): `q`=-2^(WIDTH-1) (wraps), `r`=0, no flag.
- Divide by zero (both modes): `q`=all ones, `r`=original `a`, `div_zero`=1. Same latency as a normal divide.
- `start` while `busy`=1: ignored; operands not re-sampled.
- `q`, `r`, `div_zero` hold their last result until the next completion.

## Timing

- Reset values: `q`=0, `r`=0, `busy`=0, `done`=0, `div_zero`=0, state IDLE, counter 0.
- Edge E0 accepts start → `busy`=1 after E0.
- Edges E1..E(WIDTH) iterate; after E(WIDTH): `busy`=0, `done`=1, results valid.
- Latency: WIDTH cycles from accepting edge to `done`; issue interval WIDTH+1 cycles minimum.
- `done` is high exactly one cycle; it is never high together with `busy`.
- `start` held high continuously: a new operation is accepted on the cycle `done` is high (IDLE). This gives back-to-back operation with `busy` low for one cycle.
- Reset asserted mid-operation: abort on that edge; all outputs return to reset values; no `done`.
- Reset and `start` in the same cycle: reset wins.

## Configuration

- `DIV_SIGNED_EN` defined:
  - `sign` input honoured;
  - magnitude and sign-correction logic built.
- `DIV_SIGNED_EN` not defined:
  - `sign` ignored (treated as 0); unit is unsigned-only;
  - no negation logic;
  - latency, handshake and divide-by-zero behaviour unchanged.

## Test plan

- Reset then `a`=1, `b`=2, `sign`=0, start → after 32 cycles `done`=1, `q`=0, `r`=1, `div_zero`=0.
- Unsigned `a`=0xFFFFFFFF, `b`=2 → `q`=0x7FFFFFFF, `r`=1.
  - Same operands with `sign`=1 → `q`=0, `r`=0xFFFFFFFF (-1/2).
- Signed cases:
  - `a`=-7, `b`=2 → `q`=0xFFFFFFFD (-3), `r`=0xFFFFFFFF (-1).
  - `a`=0x80000000, `b`=0xFFFFFFFF → `q`=0x80000000, `r`=0.
- `a`=55, `b`=0 → `q`=0xFFFFFFFF, `r`=55, `div_zero`=1, still 32-cycle latency.
  - Next op 55/2 → `q`=27, `r`=1, `div_zero`=0.
- Start held high with operands changed mid-op:
  - first result unaffected;
  - second op accepted on the `done` cycle.
- Reset asserted at iteration 10:
  - all outputs 0 next cycle;
  - no `done` pulse;
  - fresh op afterwards completes correctly.
